// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the architectural PC, drives the instruction
// ROM address and registers the fetched word into the IF/ID latch.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] npc_in,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        id_fault,
    output logic [31:0] fault_pc,
    output logic        fault_seen
);

    // Range bounds carried in 33 bits so the top of ROM never wraps to zero.
    localparam logic [32:0] PcLo = {1'b0, RESET_PC};
    localparam logic [32:0] PcHi = {1'b0, RESET_PC} + 33'(4 * IMEM_WORDS);

    logic [31:0] pc_q,         pc_d;
    logic [31:0] id_instr_q,   id_instr_d;
    logic [31:0] id_pc_q,      id_pc_d;
    logic        id_valid_q,   id_valid_d;
    logic        id_fault_q,   id_fault_d;
    logic [31:0] fault_pc_q,   fault_pc_d;
    logic        fault_seen_q, fault_seen_d;

    logic [32:0] pcWide;
    logic        fetchFault;

    assign pcWide     = {1'b0, pc_q};
    assign fetchFault = (pc_q[1:0] != 2'b00) || (pcWide < PcLo) || (pcWide >= PcHi);

    // PC select: a stall drops any redirect because decode re-presents it later.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            if (redirect) begin
                pc_d = npc_in;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // IF/ID capture; the delay-slot word at the current PC always enters here.
    always_comb begin
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_valid_d   = id_valid_q;
        id_fault_d   = id_fault_q;
        fault_pc_d   = fault_pc_q;
        fault_seen_d = fault_seen_q;
        if (flush) begin
            id_instr_d = NOP_WORD;
            id_pc_d    = pc_q;
            id_valid_d = 1'b0;
            id_fault_d = 1'b0;
        end else if (!stall) begin
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            id_fault_d = fetchFault;
            id_instr_d = fetchFault ? NOP_WORD : imem_rdata;
            if (fetchFault && !fault_seen_q) begin
                fault_pc_d   = pc_q;
                fault_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            id_instr_q   <= NOP_WORD;
            id_pc_q      <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_fault_q   <= 1'b0;
            fault_pc_q   <= 32'h0000_0000;
            fault_seen_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_valid_q   <= id_valid_d;
            id_fault_q   <= id_fault_d;
            fault_pc_q   <= fault_pc_d;
            fault_seen_q <= fault_seen_d;
        end
    end

    assign imem_addr  = pc_q;
    assign id_instr   = id_instr_q;
    assign id_pc      = id_pc_q;
    assign id_pc4     = id_pc_q + 32'd4;
    assign id_valid   = id_valid_q;
    assign id_fault   = id_fault_q;
    assign fault_pc   = fault_pc_q;
    assign fault_seen = fault_seen_q;

endmodule
